// File: rtl/param_bram_loader.sv
// Programmable parameter/bias loader: streams a run-time selected block of
// BRAM words into a flat register, sign- or zero-extending each word.
module param_bram_loader #(
    parameter int MAX_COUNT  = 8,
    parameter int W          = 8,
    parameter int OUT_W      = 8,
    parameter int SIGN_EXT   = 1,
    parameter int ADDR_WIDTH = 18,
    parameter int RD_LAT     = 2,
    parameter int CNT_WIDTH  = $clog2(MAX_COUNT + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [CNT_WIDTH-1:0]       count,
    output logic                       bram_en,
    output logic                       bram_ren,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    input  logic [W-1:0]               bram_dout,
    output logic [MAX_COUNT*OUT_W-1:0] data_out,
    output logic                       busy,
    output logic                       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [CNT_WIDTH-1:0]    n_q, n_d;
    logic [CNT_WIDTH-1:0]    iss_q, iss_d;
    logic [CNT_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
    logic                    en_q, en_d;
    logic                    ren_q, ren_d;
    logic [RD_LAT-1:0]       tag_q, tag_d;
    logic [OUT_W-1:0]        elem_q [MAX_COUNT];
    logic [OUT_W-1:0]        elem_d [MAX_COUNT];

    logic [OUT_W-1:0]        ext_word;
    logic [CNT_WIDTH-1:0]    n_clamped;
    logic                    capture;

    assign n_clamped = (count > CNT_WIDTH'(MAX_COUNT)) ? CNT_WIDTH'(MAX_COUNT) : count;

    // A read's tag leaves the shift register exactly when its data is on bram_dout.
    assign capture = tag_q[RD_LAT-1];

    always_comb begin
        ext_word = OUT_W'(bram_dout);
        if ((SIGN_EXT != 0) && bram_dout[W-1]) begin
            ext_word = ext_word | ~OUT_W'({W{1'b1}});
        end
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        n_d      = n_q;
        iss_d    = iss_q;
        wr_ptr_d = wr_ptr_q;
        en_d     = en_q;
        ren_d    = ren_q;
        tag_d    = (tag_q << 1) | RD_LAT'(ren_q);
        elem_d   = elem_q;

        if (capture) begin
            wr_ptr_d = wr_ptr_q + CNT_WIDTH'(1);
            for (int i = 0; i < MAX_COUNT; i++) begin
                if (wr_ptr_q == CNT_WIDTH'(i)) begin
                    elem_d[i] = ext_word;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    n_d      = n_clamped;
                    addr_d   = base_addr;
                    iss_d    = '0;
                    wr_ptr_d = '0;
                    for (int i = 0; i < MAX_COUNT; i++) begin
                        elem_d[i] = '0;
                    end
                    if (n_clamped == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        en_d    = 1'b1;
                        ren_d   = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if ((iss_q + CNT_WIDTH'(1)) == n_q) begin
                    ren_d   = 1'b0;
                    state_d = S_DRAIN;
                end else begin
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    iss_d  = iss_q + CNT_WIDTH'(1);
                end
            end
            S_DRAIN: begin
                if (wr_ptr_q == n_q) begin
                    en_d    = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            n_q      <= '0;
            iss_q    <= '0;
            wr_ptr_q <= '0;
            en_q     <= 1'b0;
            ren_q    <= 1'b0;
            tag_q    <= '0;
            // NOTE: the element array is visible on data_out, so it must reset like any register.
            for (int i = 0; i < MAX_COUNT; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            n_q      <= n_d;
            iss_q    <= iss_d;
            wr_ptr_q <= wr_ptr_d;
            en_q     <= en_d;
            ren_q    <= ren_d;
            tag_q    <= tag_d;
            for (int i = 0; i < MAX_COUNT; i++) begin
                elem_q[i] <= elem_d[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < MAX_COUNT; i++) begin
            data_out[i*OUT_W +: OUT_W] = elem_q[i];
        end
    end

    assign bram_en   = en_q;
    assign bram_ren  = ren_q;
    assign bram_addr = addr_q;
    assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_param_bram_loader.sv
// Bench for param_bram_loader: three differently configured instances share one
// stimulus stream and are checked every cycle against a timing-rule model.
module tb_param_bram_loader;

    localparam int NL   = 3;
    localparam int MAXC = 8;
    localparam int CW   = 4;

    function automatic int lane_rl(int g);
        case (g)
            0:       return 2;
            1:       return 1;
            default: return 4;
        endcase
    endfunction
    function automatic int lane_ow(int g); return (g == 0) ? 8 : 16; endfunction
    function automatic int lane_se(int g); return (g == 2) ? 0 : 1; endfunction
    function automatic int lane_aw(int g); return (g == 0) ? 18 : 4; endfunction

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [17:0]   base_addr = '0;
    logic [CW-1:0] count = '0;
    int            bram_mode = 0;

    always #5 clk = ~clk;

    logic [NL-1:0]        l_en, l_ren, l_busy, l_done;
    logic [NL-1:0][17:0]  l_addr;
    logic [NL-1:0][127:0] l_data;

    // Mode 0: word = low address byte; mode 2: constant 0x80; otherwise a hash.
    function automatic logic [7:0] mem_word(int mode, logic [17:0] a);
        case (mode)
            0:       return a[7:0];
            2:       return 8'h80;
            default: return 8'((a * 18'd13) ^ (a >> 5) ^ 18'h5A);
        endcase
    endfunction

    for (genvar g = 0; g < NL; g++) begin : g_lane
        localparam int RL = lane_rl(g);
        localparam int OW = lane_ow(g);
        localparam int SE = lane_se(g);
        localparam int AW = lane_aw(g);

        logic [AW-1:0]      addr;
        logic [MAXC*OW-1:0] dout_flat;
        logic               en, ren, busy, done;
        logic [7:0]         pipe [RL];

        always @(posedge clk) begin
            pipe[0] <= mem_word(bram_mode, 18'(addr));
            for (int i = 1; i < RL; i++) pipe[i] <= pipe[i-1];
        end

        param_bram_loader #(
            .MAX_COUNT(MAXC), .W(8), .OUT_W(OW), .SIGN_EXT(SE),
            .ADDR_WIDTH(AW), .RD_LAT(RL)
        ) dut (
            .clk(clk), .rst_n(rst_n), .start(start),
            .base_addr(base_addr[AW-1:0]), .count(count),
            .bram_en(en), .bram_ren(ren), .bram_addr(addr),
            .bram_dout(pipe[RL-1]), .data_out(dout_flat),
            .busy(busy), .done(done)
        );

        assign l_en[g]   = en;
        assign l_ren[g]  = ren;
        assign l_busy[g] = busy;
        assign l_done[g] = done;
        assign l_addr[g] = 18'(addr);
        assign l_data[g] = 128'(dout_flat);
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: per lane, the accepting edge index plus latched n/base/mode.
    bit          m_act [NL];
    int          m_a [NL];
    int          m_n [NL];
    int          m_mode [NL];
    logic [17:0] m_base [NL];
    int          cyc = 0;

    function automatic logic [17:0] lane_mask(int g);
        return (lane_aw(g) == 18) ? 18'h3FFFF : 18'h0000F;
    endfunction

    function automatic int done_at(int g);
        return (m_n[g] == 0) ? 0 : m_n[g] + lane_rl(g) + 1;
    endfunction

    function automatic logic [15:0] ext(logic [7:0] w, int g);
        logic [15:0] v;
        v = (lane_se(g) != 0 && w[7]) ? {8'hFF, w} : {8'h00, w};
        if (lane_ow(g) == 8) v[15:8] = 8'h00;
        return v;
    endfunction

    initial begin
        for (int g = 0; g < NL; g++) m_act[g] = 1'b0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int g = 0; g < NL; g++) m_act[g] = 1'b0;
            end else begin
                for (int g = 0; g < NL; g++) begin
                    if (start && (!m_act[g] || (cyc - m_a[g]) >= done_at(g))) begin
                        m_act[g]  = 1'b1;
                        m_a[g]    = cyc + 1;
                        m_n[g]    = (int'(count) > MAXC) ? MAXC : int'(count);
                        m_base[g] = base_addr & lane_mask(g);
                        m_mode[g] = bram_mode;
                    end
                end
                cyc++;
            end
        end
    end

    task automatic compare_lane(input int g);
        int           d, n, rl, ow;
        logic [127:0] e_data;
        logic [17:0]  e_addr, a_i;
        bit           e_en, e_ren, e_busy, e_done, chk_addr;
        e_data = '0; e_addr = '0;
        e_en = 0; e_ren = 0; e_busy = 0; e_done = 0; chk_addr = 1;
        if (m_act[g]) begin
            d  = cyc - m_a[g];
            n  = m_n[g];
            rl = lane_rl(g);
            ow = lane_ow(g);
            if (n == 0) begin
                e_done = 1; chk_addr = 0;
            end else if (d < n) begin
                e_en = 1; e_ren = 1; e_busy = 1;
                e_addr = (m_base[g] + 18'(d)) & lane_mask(g);
            end else if (d < n + rl + 1) begin
                e_en = 1; e_busy = 1; chk_addr = 0;
            end else begin
                e_done = 1; chk_addr = 0;
            end
            for (int i = 0; i < n; i++) begin
                if (d >= i + rl + 1) begin
                    a_i = (m_base[g] + 18'(i)) & lane_mask(g);
                    e_data = e_data | (128'(ext(mem_word(m_mode[g], a_i), g)) << (i * ow));
                end
            end
        end
        check($sformatf("lane%0d_en", g),   l_en[g],   e_en);
        check($sformatf("lane%0d_ren", g),  l_ren[g],  e_ren);
        check($sformatf("lane%0d_busy", g), l_busy[g], e_busy);
        check($sformatf("lane%0d_done", g), l_done[g], e_done);
        check($sformatf("lane%0d_data", g), l_data[g], e_data);
        if (chk_addr) check($sformatf("lane%0d_addr", g), l_addr[g], e_addr);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            for (int g = 0; g < NL; g++) compare_lane(g);
        end
    end

    logic [17:0] addr_q1 [$];

    // Pulses start for one cycle, optionally injects a second start ia cycles
    // after acceptance, then waits (bounded) for every lane to reach done.
    task automatic run_load(input logic [17:0] b, input int c, input int mode,
                            input int ia, input logic [17:0] ib, input int ic,
                            output int lat0, output int ren0, output logic [17:0] a0);
        lat0 = -1; ren0 = 0; a0 = '0;
        addr_q1.delete();
        @(negedge clk);
        bram_mode = mode; base_addr = b; count = CW'(c); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (k == ia + 1) start = 1'b0;
            if (k == 0) a0 = l_addr[0];
            if (l_ren[0]) ren0++;
            if (l_ren[1]) addr_q1.push_back(l_addr[1]);
            if (lat0 < 0 && l_done[0]) lat0 = k;
            if (&l_done) break;
            if (k == ia) begin
                start = 1'b1; base_addr = ib; count = CW'(ic);
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("load_completes", l_done, 3'b111);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, rn;
        logic [17:0] a0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_done", l_done, 3'b000);
        check("idle_data0", l_data[0], 128'h0);

        run_load(18'd147552, 8, 0, -1, 18'd0, 0, lat, rn, a0);
        check("basic_first_addr", a0, 18'd147552);
        check("basic_latency", lat, 11);
        check("basic_reads", rn, 8);
        check("basic_data", l_data[0], 128'h6766656463626160);

        run_load(18'd5, 1, 2, -1, 18'd0, 0, lat, rn, a0);
        check("sext_lane0", l_data[0][7:0], 8'h80);
        check("sext_lane1", l_data[1][15:0], 16'hFF80);
        check("zext_lane2", l_data[2][15:0], 16'h0080);

        run_load(18'd9, 0, 1, -1, 18'd0, 0, lat, rn, a0);
        check("cnt0_reads", rn, 0);
        check("cnt0_latency", lat, 0);
        check("cnt0_data", l_data[0], 128'h0);

        run_load(18'd40, 12, 1, -1, 18'd0, 0, lat, rn, a0);
        check("cnt12_reads", rn, 8);

        run_load(18'h3FFFE, 4, 0, -1, 18'd0, 0, lat, rn, a0);
        check("wrap_lane0_data", l_data[0][31:0], 32'h0100FFFE);
        check("wrap_lane1_data", l_data[1][63:0], 64'h0001_0000_000F_000E);
        check("wrap_lane1_nreads", addr_q1.size(), 4);
        if (addr_q1.size() == 4) begin
            check("wrap_addr0", addr_q1[0], 18'd14);
            check("wrap_addr1", addr_q1[1], 18'd15);
            check("wrap_addr2", addr_q1[2], 18'd0);
            check("wrap_addr3", addr_q1[3], 18'd1);
        end

        run_load(18'd100, 8, 1, 3, 18'd200, 3, lat, rn, a0);
        check("busy_start_reads", rn, 8);
        check("busy_start_latency", lat, 11);

        run_load(18'd300, 3, 1, -1, 18'd0, 0, lat, rn, a0);
        check("restart_lane0_upper", l_data[0][63:24], 40'h0);
        check("restart_lane2_upper", l_data[2][127:48], 80'h0);

        // Abort in DRAIN: outputs must clear before the next clock edge.
        @(negedge clk);
        bram_mode = 1; base_addr = 18'd77; count = CW'(8); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", l_busy, 3'b111);
        check("pre_rst_ren0", l_ren[0], 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_en", l_en, 3'b000);
        check("rst_async_busy", l_busy, 3'b000);
        check("rst_async_addr0", l_addr[0], 18'd0);
        check("rst_async_data0", l_data[0], 128'h0);
        check("rst_async_data2", l_data[2], 128'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        run_load(18'd500, 6, 1, -1, 18'd0, 0, lat, rn, a0);
        check("post_rst_reads", rn, 6);

        for (int it = 0; it < 40; it++) begin
            run_load(18'($urandom), int'($urandom_range(0, 12)), 1,
                     ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 8)),
                     18'($urandom), int'($urandom_range(0, 12)), lat, rn, a0);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_bram_loader.md
Name: param_bram_loader

Overview:
- Generalised parameter/bias loader. Reads a run-time-selected block of W-bit words from a single-port read-only BRAM into a flat parallel register for one network layer.
- Supersedes the fixed per-layer loaders. Base address, word count, BRAM read latency and optional sign-extension are programmable, so one block serves every layer.
- Sits between the shared parameter BRAM port and a layer's compute array. The BRAM is external; this block drives its read port.

Parameters:
- MAX_COUNT, 8, capacity of data_out in words.
- W, 8, BRAM word width.
- OUT_W, 8, stored element width (>= W). Elements are sign- or zero-extended from W.
- SIGN_EXT, 1, 1 = sign-extend W to OUT_W; 0 = zero-extend.
- ADDR_WIDTH, 18, BRAM address width.
- RD_LAT, 2, BRAM read latency in cycles from addr/ren to valid dout (1..4).
- CNT_WIDTH, $clog2(MAX_COUNT+1), width of the count input.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  load request, sampled only in IDLE or DONE.
- base_addr  input  ADDR_WIDTH  first BRAM address, latched on accepted start.
- count  input  CNT_WIDTH  words to load, latched on accepted start.
- bram_en  output  1  BRAM enable.
- bram_ren  output  1  BRAM read strobe, one address per cycle.
- bram_addr  output  ADDR_WIDTH  BRAM read address.
- bram_dout  input  W  BRAM read data, valid RD_LAT cycles after its address.
- data_out  output  MAX_COUNT*OUT_W  element i at [i*OUT_W +: OUT_W].
- busy  output  1  high in ISSUE and DRAIN.
- done  output  1  level; high in DONE until next accepted start or reset.

Behaviour:
- Reset (async assert, sync release): state=IDLE; bram_en=0, bram_ren=0, bram_addr=0; data_out=0; busy=0; done=0; counters cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE/DONE with start=1 (accepted start):
  - latch base_addr and n=min(count,MAX_COUNT); clear data_out and done.
  - If n=0, go to DONE. done is high the next cycle; no BRAM access.
  - Otherwise go to ISSUE with bram_en=1, bram_ren=1, bram_addr=base_addr.
- ISSUE: one read per cycle. bram_addr increments each cycle for exactly n reads (base..base+n-1).
  - After the n-th address cycle, drop bram_ren and go to DRAIN. bram_en stays 1.
- Capture: an RD_LAT-deep valid shift register tags each issued read.
  - When the tag emerges, bram_dout is extended per SIGN_EXT and written to data_out[wr_ptr]; wr_ptr increments.
  - Words land in address order: element 0 = base_addr.
- DRAIN: continue capture until wr_ptr==n, then bram_en=0 and go to DONE.
- Latency: first address on the cycle after start is accepted. done rises exactly n+RD_LAT+1 cycles after the accepting edge.
- start while busy: ignored, no effect on latched parameters.
- Restart from DONE: start is accepted. data_out clears on that edge (elements >= n read 0 after the new load).
- Address wrap: base_addr+i is computed modulo 2^ADDR_WIDTH. No error flag.
- Entries at index >= n stay 0.
- Reset mid-operation: immediate abort to reset values. A late BRAM dout is never captured.
- busy and done are never both 1. done=1 implies data_out is stable.

Test Plan:
- Basic load, RD_LAT=2, n=8, base=147552, BRAM[addr]=addr[7:0] -> addresses 147552..147559 on 8 consecutive cycles; done at cycle 11 after start; data_out elements = 0x60..0x67.
- Sign extension, OUT_W=16, SIGN_EXT=1, BRAM word 0x80 -> element 0xFF80. With SIGN_EXT=0 -> 0x0080.
- count=0 -> no bram_ren pulse; done next cycle; data_out=0. count=12 with MAX_COUNT=8 -> exactly 8 reads.
- Wrap, ADDR_WIDTH=4, base=14, n=4 -> addresses 14,15,0,1; data in that order.
- start pulsed during ISSUE with different base/count -> ignored; original load completes unchanged. Restart from DONE with n=3 -> elements 3..7 read 0.
- rst_n low in DRAIN -> all outputs zero asynchronously; after release, no stray capture; a new start loads correctly. Repeat with RD_LAT=1 and 4.
